stage_mem_bus: RTL and testbench
================================

// Module: stage_mem_bus
// PURPOSE
//   Data memory for the MEM stage, successor to the fixed word-only memory.
//   Adds byte/halfword/word loads and stores with sign/zero extension and a
//   programmable access latency behind a req/ready/done handshake.
//   The pipeline stalls MEM while an access is outstanding.
//   Little-endian; ops are strictly serialised.
// PARAMETERS
//   ADDR_WIDTH  12  byte-address bits decoded; array = 2^(ADDR_WIDTH-2) words
//   LATENCY     1   cycles from accept to done; legal range 1..15
// PORTS
//   clk         in   1   clock
//   reset       in   1   synchronous, active-high
//   req         in   1   access request
//   we          in   1   1 = store, 0 = load (sampled at accept)
//   size        in   2   00 byte, 01 half, 10 word, 11 reserved
//   unsign      in   1   load zero-extend (lbu/lhu); ignored for word/store
//   addr        in   32  byte address; bits above ADDR_WIDTH-1 ignored (wrap)
//   write_data  in   32  store data, right-aligned (sb: [7:0], sh: [15:0])
//   ready       out  1   request accepted on this edge if req=1
//   done        out  1   one-cycle pulse: access complete
//   read_data   out  32  extended load result; valid while done=1
//   exc         out  1   alignment fault, valid while done=1
// BEHAVIOUR
//   - Interface is fixed: one clock (clk); reset is synchronous, active-high.
//   - Reset: all words <- 0, state IDLE, cnt 0, done=0, read_data=0, exc=0, ready=1.
//   - Reset mid-access aborts it. No write occurs, and no done is produced.
//   - States: IDLE, BUSY, DONE. ready = (state != BUSY).
//   - Accept: req&ready at an edge latches we/size/unsign/addr/write_data.
//     If LATENCY==1, perform the op at that edge and go to DONE.
//     Otherwise cnt <- LATENCY-1 and go to BUSY.
//   - BUSY: at each edge, if cnt==1 perform the op and go to DONE; else cnt--.
//     Result: done is high exactly LATENCY cycles after the accept cycle.
//   - DONE: done=1 for exactly one cycle.
//     If req is high, accept back-to-back (same rules as IDLE); else go to IDLE.
//   - Perform (single edge):
//     store: update only the addressed byte lanes.
//     load: register the extended data into read_data.
//   - read_data holds its value until the next load completes.
//     exc clears at the next perform.
//   - Lanes: byte lane = addr[1:0], lane 0 = bits [7:0].
//     Half: addr[1]=0 -> [15:0], addr[1]=1 -> [31:16].
//   - Loads: byte/half are sign-extended unless unsign=1. Word is returned as stored.
//   - Inputs are ignored while BUSY. The array is never written outside a perform.
// CONFIGURATION
//   DMEM_ALIGN_CHECK_EN defined:
//     - Misaligned access is a fault: half with addr[0]=1, word with
//       addr[1:0]!=0, or size=11.
//     - On a fault: no write; read_data <- 0; exc=1 in the done cycle.
//     - Latency is unchanged.
//   DMEM_ALIGN_CHECK_EN undefined:
//     - exc is tied to 0.
//     - Half ignores addr[0]; word ignores addr[1:0]; size=11 is treated as word.
// TESTING
//   1 LATENCY=1: sw 0x8899AABB @0x10, then lw @0x10
//     -> done 1 cycle after each accept; read_data=0x8899AABB
//   2 sb 0x7F @0x11, sb 0x80 @0x12 over 0; lb @0x12 -> 0xFFFFFF80;
//     lbu @0x12 -> 0x00000080; lw @0x10 -> 0x00807F00
//   3 sh 0xBEEF @0x22; lh @0x22 -> 0xFFFFBEEF; lhu -> 0x0000BEEF;
//     lw @0x20 -> 0xBEEF0000
//   4 LATENCY=4, back-to-back reqs held high -> ready low 3 cycles per access;
//     done every 4th cycle; a load after a store to the same address returns the new data
//   5 reset asserted in BUSY during sw @0x0 -> no done; lw @0x0 -> 0; ready=1 after reset
//   6 DMEM_ALIGN_CHECK_EN: sw @0x13 -> exc=1, memory unchanged;
//     without the macro -> writes word 0x10, exc=0

Source files
------------

// File: rtl/stage_mem_bus.sv
// stage_mem_bus: MEM-stage data memory with byte/half/word access, sign/zero
// extended loads and a programmable access latency behind req/ready/done.
// Optional feature: define DMEM_ALIGN_CHECK_EN to fault misaligned accesses
// (exc=1, no write, read_data=0). Without it exc is 0 and low address bits
// below the access size are ignored; size=11 behaves as word.
module stage_mem_bus #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsign,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        ready,
    output logic        done,
    output logic [31:0] read_data,
    output logic        exc
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    we_q;
    logic                    unsign_q;
    logic [1:0]              size_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             mem [DEPTH];

    // Operand view used by the perform edge: live inputs on a single-cycle
    // accept, latched copies once the access has been waiting in BUSY.
    logic                    op_we;
    logic                    op_unsign;
    logic [1:0]              op_size;
    logic [ADDR_WIDTH-1:0]   op_addr;
    logic [31:0]             op_wdata;
    logic [31:0]             cur_word;
    logic [3:0]              be;
    logic [31:0]             wword;
    logic [31:0]             load_val;
    logic                    fault;
    logic                    accept;
    logic                    perform;
    logic [7:0]              byte_val;
    logic [15:0]             half_val;

    // Address bits above the decoded range wrap and are intentionally unused.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH];

    assign ready   = (state != BUSY);
    assign accept  = req && (state != BUSY);
    assign perform = (accept && (LATENCY == 1)) || ((state == BUSY) && (cnt == 4'd1));

    assign op_we     = (state == BUSY) ? we_q     : we;
    assign op_unsign = (state == BUSY) ? unsign_q : unsign;
    assign op_size   = (state == BUSY) ? size_q   : size;
    assign op_addr   = (state == BUSY) ? addr_q   : addr[ADDR_WIDTH-1:0];
    assign op_wdata  = (state == BUSY) ? wdata_q  : write_data;
    assign cur_word  = mem[op_addr[ADDR_WIDTH-1:2]];

    // Lane decode, store merge data, load extraction/extension and fault check.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        be       = 4'b0000;
        wword    = op_wdata;
        load_val = cur_word;
        byte_val = cur_word[{op_addr[1:0], 3'b000} +: 8];
        half_val = op_addr[1] ? cur_word[31:16] : cur_word[15:0];
        case (op_size)
            2'b00: begin
                be       = 4'b0001 << op_addr[1:0];
                wword    = {4{op_wdata[7:0]}};
                load_val = {{24{~op_unsign & byte_val[7]}}, byte_val};
            end
            2'b01: begin
                be       = op_addr[1] ? 4'b1100 : 4'b0011;
                wword    = {2{op_wdata[15:0]}};
                load_val = {{16{~op_unsign & half_val[15]}}, half_val};
            end
            default: begin
                be       = 4'b1111;
                wword    = op_wdata;
                load_val = cur_word;
            end
        endcase
`ifdef DMEM_ALIGN_CHECK_EN
        fault = (op_size == 2'b11) ||
                ((op_size == 2'b01) && op_addr[0]) ||
                ((op_size == 2'b10) && (op_addr[1:0] != 2'b00));
`else
        fault = 1'b0;
`endif
    end

    // Handshake FSM, latency counter, array update and registered results.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the array is cleared by reset, so it lives in this block
            // and cannot map onto a plain RAM macro without a clear sequence.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            state     <= IDLE;
            cnt       <= '0;
            done      <= 1'b0;
            read_data <= '0;
            exc       <= 1'b0;
            we_q      <= 1'b0;
            unsign_q  <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            done <= perform;
            case (state)
                IDLE, DONE: begin
                    if (req) begin
                        we_q     <= we;
                        unsign_q <= unsign;
                        size_q   <= size;
                        addr_q   <= addr[ADDR_WIDTH-1:0];
                        wdata_q  <= write_data;
                        if (LATENCY == 1) begin
                            state <= DONE;
                        end else begin
                            cnt   <= 4'(LATENCY - 1);
                            state <= BUSY;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd1) state <= DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
            if (perform) begin
                exc <= fault;
                if (fault) begin
                    read_data <= '0;
                end else if (op_we) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mem[op_addr[ADDR_WIDTH-1:2]][8*b +: 8] <= wword[8*b +: 8];
                end else begin
                    read_data <= load_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_stage_mem_bus.sv
// tb_stage_mem_bus: two instances (LATENCY=1 and LATENCY=4) driven in turn;
// a byte-array reference model predicts each access, a monitor checks done.
module tb_stage_mem_bus;

    localparam int AW = 12;

    typedef struct {
        int          inst;
        logic [31:0] rd;
        logic        exc;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_s    [2];
    logic        we_s     [2];
    logic [1:0]  size_s   [2];
    logic        unsign_s [2];
    logic [31:0] addr_s   [2];
    logic [31:0] wdata_s  [2];
    logic        ready_s  [2];
    logic        done_s   [2];
    logic [31:0] rdata_s  [2];
    logic        exc_s    [2];

    int          lat [2] = '{1, 4};
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    exp_t        q[$];
    logic [7:0]  mem_m [2][4096];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stage_mem_bus #(.ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]), .size(size_s[0]),
        .unsign(unsign_s[0]), .addr(addr_s[0]), .write_data(wdata_s[0]),
        .ready(ready_s[0]), .done(done_s[0]), .read_data(rdata_s[0]), .exc(exc_s[0]));

    stage_mem_bus #(.ADDR_WIDTH(AW), .LATENCY(4)) dut4 (
        .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]), .size(size_s[1]),
        .unsign(unsign_s[1]), .addr(addr_s[1]), .write_data(wdata_s[1]),
        .ready(ready_s[1]), .done(done_s[1]), .read_data(rdata_s[1]), .exc(exc_s[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: memory as bytes, little-endian, access width from size.
    task automatic model(input int i, input bit w, input bit [1:0] s, input bit u,
                         input logic [31:0] a, input logic [31:0] d, output exp_t e);
        int base, nb;
        bit f;
        logic [31:0] v;
        f    = 1'b0;
        v    = '0;
        base = int'(a[AW-1:0]);
        nb   = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
`ifdef DMEM_ALIGN_CHECK_EN
        f = (s == 2'd3) || (base % nb != 0);
`endif
        base  = base - (base % nb);
        e.inst = i;
        e.exc  = f;
        if (f) begin
            last_rd[i] = '0;
        end else if (w) begin
            for (int k = 0; k < nb; k++) mem_m[i][base + k] = d[8*k +: 8];
        end else begin
            for (int k = 0; k < nb; k++) v = v | (32'(mem_m[i][base + k]) << (8 * k));
            if (nb < 4 && !u && v[8*nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            last_rd[i] = v;
        end
        e.rd = last_rd[i];
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            last_rd[i] = '0;
            for (int k = 0; k < 4096; k++) mem_m[i][k] = '0;
        end
    endtask

    // Present one op, wait for ready, and return just after the accepting edge.
    task automatic issue(input int i, input bit w, input bit [1:0] s, input bit u,
                         input logic [31:0] a, input logic [31:0] d);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        we_s[i] = w; size_s[i] = s; unsign_s[i] = u; addr_s[i] = a; wdata_s[i] = d;
        req_s[i] = 1'b1;
        while (!ready_s[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_s[i]) begin
            check("accept_timeout", 32'(ready_s[i]), 32'd1);
            req_s[i] = 1'b0;
            return;
        end
        model(i, w, s, u, a, d, e);
        e.acc = cyc;
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input int i, input int n);
        @(negedge clk);
        req_s[i] = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic drain(input int i);
        int n;
        n = 0;
        idle(i, 1);
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic rand_ops(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            issue(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom & 32'hFFFF_F03F, $urandom);
            if ($urandom_range(0, 2) == 0) idle(i, $urandom_range(1, 3));
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                if (done_s[i]) begin
                    if (q.size() == 0 || q[0].inst != i) begin
                        check("unexpected_done", 32'(i), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("read_data", rdata_s[i], e.rd);
                        check("exc", 32'(exc_s[i]), 32'(e.exc));
                        check("latency", 32'(cyc - e.acc), 32'(lat[i]));
                        check("ready_in_done", 32'(ready_s[i]), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_s[i] = 1'b0; we_s[i] = 1'b0; size_s[i] = '0; unsign_s[i] = 1'b0;
            addr_s[i] = '0; wdata_s[i] = '0;
        end
        clear_model();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 32'(ready_s[i]), 32'd1);
            check("rst_done", 32'(done_s[i]), 32'd0);
            check("rst_read_data", rdata_s[i], 32'd0);
            check("rst_exc", 32'(exc_s[i]), 32'd0);
        end

        // LATENCY=1 directed: word, byte and half accesses.
        issue(0, 1, 2'b10, 0, 32'h10, 32'h8899_AABB);
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0);
        issue(0, 1, 2'b10, 0, 32'h10, 32'h0);
        issue(0, 1, 2'b00, 0, 32'h11, 32'h0000_007F);
        issue(0, 1, 2'b00, 0, 32'h12, 32'h0000_0080);
        issue(0, 0, 2'b00, 0, 32'h12, 32'h0);
        issue(0, 0, 2'b00, 1, 32'h12, 32'h0);
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0);
        issue(0, 1, 2'b01, 0, 32'h22, 32'h0000_BEEF);
        issue(0, 0, 2'b01, 0, 32'h22, 32'h0);
        issue(0, 0, 2'b01, 1, 32'h22, 32'h0);
        issue(0, 0, 2'b10, 0, 32'h20, 32'h0);
        // Misaligned word store, then observe the containing word.
        issue(0, 1, 2'b10, 0, 32'h13, 32'h1122_3344);
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0);
        drain(0);
        rand_ops(0, 150);
        drain(0);

        // LATENCY=4: back-to-back store/load pairs with req held high.
        issue(1, 1, 2'b10, 0, 32'h40, 32'h1234_5678);
        issue(1, 0, 2'b10, 0, 32'h40, 32'h0);
        issue(1, 1, 2'b01, 0, 32'h42, 32'h0000_8001);
        issue(1, 0, 2'b01, 0, 32'h42, 32'h0);
        issue(1, 0, 2'b10, 0, 32'h40, 32'h0);
        drain(1);
        rand_ops(1, 100);
        drain(1);

        // Reset while BUSY aborts the store and produces no done.
        issue(1, 1, 2'b10, 0, 32'h0, 32'hDEAD_BEEF);
        @(negedge clk);
        req_s[1] = 1'b0;
        reset    = 1'b1;
        clear_model();
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("abort_ready", 32'(ready_s[i]), 32'd1);
            check("abort_read_data", rdata_s[i], 32'd0);
        end
        repeat (5) @(negedge clk);
        issue(1, 0, 2'b10, 0, 32'h0, 32'h0);
        drain(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
